// File: rtl/mult_arb_pkg.sv
// Shared types for the shared Booth-multiplier arbiter: operand/response records
// and the requester index type.
package mult_arb_pkg;
  localparam int NUM_REQ_MAX = 8;
  localparam int MULT_DATA_W = 8;
  localparam int MULT_RES_W  = 16;
  localparam int MULT_TAG_W  = 4;

  // Wide enough for any legal requester count, so one type serves every instance.
  typedef logic [$clog2(NUM_REQ_MAX)-1:0] req_id_t;

  typedef struct packed {
    logic signed [MULT_DATA_W-1:0] a;
    logic signed [MULT_DATA_W-1:0] b;
    logic        [MULT_TAG_W-1:0]  tag;
  } mult_req_t;

  typedef struct packed {
    logic [MULT_RES_W-1:0] dat;
    logic [MULT_TAG_W-1:0] tag;
  } mult_rsp_t;
endpackage

// File: rtl/mult_8b.sv
// Signed 8x8 radix-4 Booth multiplier with a single registered output stage:
// operands presented in cycle T give the product on d_dat in cycle T+1.
module mult_8b (
  input  logic              clk,
  input  logic              rst_n,
  input  logic signed [7:0] a_dat0,
  input  logic signed [7:0] b_dat0,
  input  logic              msg_in_vld,
  output logic [15:0]       d_dat,
  output logic              msg_out_vld
);
  logic signed [15:0] w_a_ext;
  logic signed [15:0] w_pp;
  logic signed [15:0] w_prod;
  logic [8:0]         w_b_ext;
  logic [2:0]         w_grp;

  always_comb begin
    w_a_ext = {{8{a_dat0[7]}}, a_dat0};
    w_b_ext = {b_dat0, 1'b0};
    w_pp    = '0;
    w_grp   = '0;
    w_prod  = '0;
    // Each overlapping 3-bit group of b selects 0, +-a or +-2a at weight 4^j.
    for (int j = 0; j < 4; j++) begin
      w_grp = w_b_ext[2*j +: 3];
      case (w_grp)
        3'b001, 3'b010: w_pp = w_a_ext;
        3'b011:         w_pp = w_a_ext <<< 1;
        3'b100:         w_pp = -(w_a_ext <<< 1);
        3'b101, 3'b110: w_pp = -w_a_ext;
        default:        w_pp = '0;
      endcase
      w_prod = w_prod + (w_pp <<< (2*j));
    end
  end

  // ---- output stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_dat       <= '0;
      msg_out_vld <= 1'b0;
    end else begin
      d_dat       <= w_prod;
      msg_out_vld <= msg_in_vld;
    end
  end
endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant among eligible inputs starting at the
// priority pointer; the pointer moves past the winner only when a grant is made.
module rr_arb
  import mult_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_elig,
  output logic [N-1:0] o_gnt,
  output req_id_t      o_gnt_id,
  output logic         o_gnt_any
);
  req_id_t r_ptr;

  always_comb begin
    int idx;
    o_gnt     = '0;
    o_gnt_id  = '0;
    o_gnt_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      for (int i = 0; i < N; i++) begin
        if (!o_gnt_any && i_elig[i] && (i == idx)) begin
          o_gnt[i]  = 1'b1;
          o_gnt_id  = req_id_t'(i);
          o_gnt_any = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_gnt_any) begin
      r_ptr <= (o_gnt_id == req_id_t'(N-1)) ? '0 : o_gnt_id + 1'b1;
    end
  end
endmodule

// File: rtl/mult_8b_arb.sv
// Shares one mult_8b between NUM_REQ requesters: round-robin issue, one in-flight
// op tracked alongside the multiplier stage, and a one-entry response slot per port.
module mult_8b_arb
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_WTH = MULT_DATA_W,
  parameter int RES_WTH  = MULT_RES_W,
  parameter int TAG_WTH  = MULT_TAG_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [NUM_REQ-1:0]                req_vld,
  output logic [NUM_REQ-1:0]                req_rdy,
  input  logic [NUM_REQ-1:0][DATA_WTH-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_WTH-1:0]  req_b,
  input  logic [NUM_REQ-1:0][TAG_WTH-1:0]   req_tag,
  output logic [NUM_REQ-1:0]                rsp_vld,
  input  logic [NUM_REQ-1:0]                rsp_rdy,
  output logic [NUM_REQ-1:0][RES_WTH-1:0]   rsp_dat,
  output logic [NUM_REQ-1:0][TAG_WTH-1:0]   rsp_tag,
  output logic                              busy
);
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  req_id_t            w_gnt_id;
  logic               w_gnt_any;
  mult_req_t          w_req;
  logic [RES_WTH-1:0] w_d_dat;
  logic               w_d_vld;
  logic               w_cap;

  logic               r_infl_vld;
  req_id_t            r_infl_id;
  logic [TAG_WTH-1:0] r_infl_tag;
  logic [NUM_REQ-1:0] r_rsp_vld;
  mult_rsp_t          r_rsp [NUM_REQ];

  // Grants are held off during reset so req_rdy reads 0 while rst_n is low.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = rst_n & req_vld[i] & ~flush
                & ~(r_infl_vld && (r_infl_id == req_id_t'(i)))
                & (~r_rsp_vld[i] | rsp_rdy[i]);
    end
  end

  rr_arb #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_elig    (w_elig),
    .o_gnt     (w_gnt),
    .o_gnt_id  (w_gnt_id),
    .o_gnt_any (w_gnt_any)
  );

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_req.a   = req_a[i];
        w_req.b   = req_b[i];
        w_req.tag = req_tag[i];
      end
    end
  end

  mult_8b u_mult (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_dat0      (w_req.a),
    .b_dat0      (w_req.b),
    .msg_in_vld  (w_gnt_any),
    .d_dat       (w_d_dat),
    .msg_out_vld (w_d_vld)
  );

  assign w_cap = r_infl_vld & w_d_vld & ~flush;

  // ---- issue -> multiplier stage: in-flight tracking ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_infl_vld <= 1'b0;
      r_infl_id  <= '0;
      r_infl_tag <= '0;
    end else begin
      r_infl_vld <= w_gnt_any & ~flush;
      if (w_gnt_any) begin
        r_infl_id  <= w_gnt_id;
        r_infl_tag <= w_req.tag;
      end
    end
  end

  // ---- multiplier -> response slots ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_vld <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_rsp[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush) begin
          r_rsp_vld[i] <= 1'b0;
        end else if (w_cap && (r_infl_id == req_id_t'(i))) begin
          r_rsp_vld[i]   <= 1'b1;
          r_rsp[i].dat   <= w_d_dat;
          r_rsp[i].tag   <= r_infl_tag;
        end else if (rsp_rdy[i]) begin
          r_rsp_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rsp_dat = '0;
    rsp_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_dat[i] = r_rsp[i].dat;
      rsp_tag[i] = r_rsp[i].tag;
    end
  end

  assign req_rdy = w_gnt;
  assign rsp_vld = r_rsp_vld;
  assign busy    = r_infl_vld | (|r_rsp_vld);
endmodule

// File: tb/tb_mult_8b_arb.sv
// Scenario bench for mult_8b_arb: a negedge monitor keeps a per-port scoreboard of
// expected products, while each scenario task checks timing and control inline.
module tb_mult_8b_arb;
  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush = 1'b0;
  logic [N-1:0]        req_vld = '0;
  logic [N-1:0]        req_rdy;
  logic [N-1:0][7:0]   req_a = '0;
  logic [N-1:0][7:0]   req_b = '0;
  logic [N-1:0][3:0]   req_tag = '0;
  logic [N-1:0]        rsp_vld;
  logic [N-1:0]        rsp_rdy = '1;
  logic [N-1:0][15:0]  rsp_dat;
  logic [N-1:0][3:0]   rsp_tag;
  logic                busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [15:0] dat;
    logic [3:0]  tag;
  } exp_t;
  exp_t sb[$];

  mult_8b_arb dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .req_a   (req_a),
    .req_b   (req_b),
    .req_tag (req_tag),
    .rsp_vld (rsp_vld),
    .rsp_rdy (rsp_rdy),
    .rsp_dat (rsp_dat),
    .rsp_tag (rsp_tag),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int pa;
    int pb;
    pa = int'($signed(a));
    pb = int'($signed(b));
    return 16'(pa * pb);
  endfunction

  // Handshakes seen at the negedge complete on the following posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (rsp_vld[i] && rsp_rdy[i]) begin
          int hit;
          hit = -1;
          for (int k = 0; k < sb.size(); k++)
            if (hit < 0 && sb[k].id == i) hit = k;
          checks++;
          if (hit < 0) begin
            errors++;
            $display("FAIL sb_unexpected port %0d got dat=%h tag=%h, no product outstanding", i, rsp_dat[i], rsp_tag[i]);
          end else begin
            if (rsp_dat[i] !== sb[hit].dat || rsp_tag[i] !== sb[hit].tag) begin
              errors++;
              $display("FAIL sb_data port %0d got dat=%h tag=%h expected dat=%h tag=%h",
                       i, rsp_dat[i], rsp_tag[i], sb[hit].dat, sb[hit].tag);
            end
            sb.delete(hit);
          end
        end
      end
      checks++;
      if ($countones(req_rdy) > 1) begin
        errors++;
        $display("FAIL grant_onehot req_rdy=%b expected at most one bit", req_rdy);
      end
      for (int i = 0; i < N; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          exp_t e;
          e.id  = i;
          e.dat = ref_mul(req_a[i], req_b[i]);
          e.tag = req_tag[i];
          sb.push_back(e);
        end
      end
    end
    if (!rst_n || flush) sb.delete();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i]   = 8'($urandom);
      req_b[i]   = 8'($urandom);
      req_tag[i] = 4'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    req_vld = '1;
    rand_ops();
    repeat (2) @(negedge clk);
    checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_req_rdy got %b expected 0000", req_rdy); end
    checks++; if (rsp_vld !== 4'b0000) begin errors++; $display("FAIL reset_rsp_vld got %b expected 0000", rsp_vld); end
    checks++; if (rsp_dat !== '0) begin errors++; $display("FAIL reset_rsp_dat got %h expected 0", rsp_dat); end
    checks++; if (rsp_tag !== '0) begin errors++; $display("FAIL reset_rsp_tag got %h expected 0", rsp_tag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    cyc();
    rst_n   = 1'b1;
    req_vld = '0;
    repeat (2) cyc();
  endtask

  task automatic test_single();
    cyc();
    req_a[0] = 8'h03; req_b[0] = 8'h05; req_tag[0] = 4'h1;
    req_vld  = 4'b0001;
    @(negedge clk);
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL single_grant got %b expected 0001", req_rdy); end
    cyc();
    req_vld = '0;
    @(negedge clk);
    checks++; if (rsp_vld !== 4'b0000) begin errors++; $display("FAIL single_early_rsp got %b expected 0000", rsp_vld); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b expected 1", busy); end
    cyc();
    @(negedge clk);
    checks++; if (rsp_vld !== 4'b0001) begin errors++; $display("FAIL single_rsp_vld got %b expected 0001", rsp_vld); end
    checks++; if (rsp_dat[0] !== 16'h000F) begin errors++; $display("FAIL single_dat got %h expected 000F", rsp_dat[0]); end
    checks++; if (rsp_tag[0] !== 4'h1) begin errors++; $display("FAIL single_tag got %h expected 1", rsp_tag[0]); end
    repeat (2) cyc();
  endtask

  task automatic test_signed();
    logic [7:0]  ta [3] = '{8'hFF, 8'h80, 8'h7F};
    logic [7:0]  tb [3] = '{8'h02, 8'h80, 8'h81};
    logic [15:0] te [3] = '{16'hFFFE, 16'h4000, 16'hC0FF};
    for (int k = 0; k < 3; k++) begin
      cyc();
      req_a[3] = ta[k]; req_b[3] = tb[k]; req_tag[3] = 4'(k + 5);
      req_vld  = 4'b1000;
      @(negedge clk);
      checks++; if (req_rdy !== 4'b1000) begin errors++; $display("FAIL signed_grant[%0d] got %b expected 1000", k, req_rdy); end
      cyc();
      req_vld = '0;
      cyc();
      @(negedge clk);
      checks++;
      if (rsp_vld[3] !== 1'b1 || rsp_dat[3] !== te[k]) begin
        errors++;
        $display("FAIL signed_prod[%0d] got vld=%b dat=%h expected vld=1 dat=%h", k, rsp_vld[3], rsp_dat[3], te[k]);
      end
      repeat (2) cyc();
    end
  endtask

  task automatic test_fairness();
    int exp_id;
    exp_id = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      rand_ops();
      req_vld = '1;
      @(negedge clk);
      checks++;
      if (req_rdy !== 4'(1 << exp_id)) begin
        errors++;
        $display("FAIL rr_order cycle %0d got %b expected %b", c, req_rdy, 4'(1 << exp_id));
      end
      exp_id = (exp_id + 1) % N;
    end
    cyc();
    req_vld = '0;
    repeat (4) cyc();
  endtask

  task automatic test_backpressure();
    logic [15:0] held_dat;
    logic [3:0]  held_tag;
    bit          seen;
    seen = 1'b0;
    rsp_rdy = 4'b1011;
    for (int c = 0; c < 10 && !seen; c++) begin
      cyc();
      rand_ops();
      req_vld = '1;
      @(negedge clk);
      if (rsp_vld[2]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_fill rsp_vld[2] got 0 expected 1 within 10 cycles"); end
    held_dat = rsp_dat[2];
    held_tag = rsp_tag[2];
    for (int c = 0; c < 5; c++) begin
      cyc();
      rand_ops();
      @(negedge clk);
      checks++;
      if (rsp_vld[2] !== 1'b1 || rsp_dat[2] !== held_dat || rsp_tag[2] !== held_tag) begin
        errors++;
        $display("FAIL bp_hold got vld=%b dat=%h tag=%h expected vld=1 dat=%h tag=%h",
                 rsp_vld[2], rsp_dat[2], rsp_tag[2], held_dat, held_tag);
      end
      checks++;
      if (req_rdy[2] !== 1'b0 || req_rdy === 4'b0000) begin
        errors++;
        $display("FAIL bp_grants got req_rdy=%b expected bit2 low and another bit high", req_rdy);
      end
    end
    cyc();
    req_vld = 4'b0100;
    rsp_rdy = '1;
    @(negedge clk);
    checks++;
    if (req_rdy !== 4'b0100 || rsp_vld[2] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got req_rdy=%b rsp_vld2=%b expected 0100 and 1", req_rdy, rsp_vld[2]);
    end
    cyc();
    req_vld = '0;
    cyc();
    @(negedge clk);
    checks++;
    if (rsp_vld[2] !== 1'b1) begin errors++; $display("FAIL bp_new_rsp got %b expected 1", rsp_vld[2]); end
    repeat (4) cyc();
  endtask

  task automatic test_flush();
    cyc();
    rand_ops();
    req_vld = 4'b0010;
    @(negedge clk);
    checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL flush_grant got %b expected 0010", req_rdy); end
    cyc();
    flush   = 1'b1;
    req_vld = 4'b1101;
    @(negedge clk);
    checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL flush_nogrant got %b expected 0000", req_rdy); end
    cyc();
    flush   = 1'b0;
    req_vld = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b expected 0", busy); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rsp_vld !== 4'b0000) begin errors++; $display("FAIL flush_rsp cycle %0d got %b expected 0000", c, rsp_vld); end
      cyc();
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    cyc();
    rsp_rdy = '0;
    rand_ops();
    req_vld = 4'b0011;
    cyc();
    cyc();
    req_vld = 4'b0111;
    @(negedge clk);
    checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL ar_grant2 got %b expected 0100", req_rdy); end
    cyc();
    checks++;
    if (rsp_vld !== 4'b0011 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ar_prefill got rsp_vld=%b busy=%b expected 0011 1", rsp_vld, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_rdy !== '0 || rsp_vld !== '0 || rsp_dat !== '0 || rsp_tag !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ar_clear got req_rdy=%b rsp_vld=%b rsp_dat=%h rsp_tag=%h busy=%b expected all 0",
               req_rdy, rsp_vld, rsp_dat, rsp_tag, busy);
    end
    cyc();
    req_vld = '1;
    rsp_rdy = '1;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL ar_first_grant got %b expected 0001", req_rdy); end
    cyc();
    req_vld = '0;
    repeat (4) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_fairness();
    test_backpressure();
    test_flush();
    test_async_reset();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d outstanding expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
